alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle issue/writeback controller that drives the 4-bit ALU's A/B/OP inputs and consumes its Y output. It accepts one 12-bit instruction at a time over a valid/ready handshake, reads operands from an internal 4×4-bit register file, and issues the ALU operation. It then writes Y back to the destination register, reports completion, and maintains a zero flag. It sits between instruction fetch and the combinational ALU in the 4-bit core.

## Interface
- WIDTH, 4: datapath width (fixed at 4; ALU shift logic is 4-bit only)
- NREGS, 4: register count (fixed; 2-bit register addresses)

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  high only in IDLE
- instr  input  12  [11:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_op  output  ALU_OP_LEN  to ALU OP
- alu_y  input  WIDTH  from ALU Y
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  value written (0 on illegal)
- err  output  1  pulses with done on illegal opcode
- zflag  output  1  set when last legal result == 0
- dbg_addr  input  2  debug read address
- dbg_data  output  WIDTH  combinational read of reg[dbg_addr]

## Operation
- Opcode decode:
  - opcode[3]=0: B = reg[rs].
  - opcode[3]=1: B = imm.
  - A = reg[rd] in all cases.
  - opcode[2:0] in {ADD, SUB, NAND, XOR, SRL, SRA} (shared params codes): alu_op = opcode[2:0].
  - ALU result is captured from alu_y.
- MOV (4'b0110): result = reg[rs], ALU bypassed.
- LDI (4'b1110): result = imm, ALU bypassed.
- During MOV/LDI, alu_op drives ADD and alu_a/alu_b hold their operands; alu_y is ignored.
- Illegal opcodes 4'b0111 and 4'b1111 (and any opcode[2:0] not in the shared ALU code set):
  - No register write, zflag unchanged.
  - result = 0; err pulses with done.
- rd == rs is legal. Operands are read before writeback, so the old value is used.
- Shift amount is B[1:0]. B[3:2] is passed unchanged; the ALU ignores it.
- Arithmetic is modulo 16. There is no carry or overflow output.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch instr → EXEC.
  - EXEC: drive alu_* from the latched instruction and the register file. At the clock edge, capture result_q ← alu_y (or bypass/0) → WB.
  - WB: done=1, result=result_q, write reg[rd] if legal, update zflag → IDLE.
- No back-to-back accept: throughput is one instruction per 3 cycles.

## Timing
- Reset state (async, immediate on rst_n low):
  - FSM in IDLE; all registers, result, zflag at 0.
  - done=0, err=0, instr_ready=1.
  - alu_a=0, alu_b=0, alu_op=ADD.
- Accept at edge T0 (instr_valid & instr_ready). EXEC runs from T0 to T1.
- alu_* outputs are stable for the whole EXEC cycle. They are combinational from registered state only, with no path from instr.
- done, result and err are valid during the WB cycle (T1 to T2). reg[rd] and zflag update at T2.
- dbg_data reflects the new value from T2.
- instr is ignored outside IDLE. instr_valid may stay high; the next instruction is accepted at T3 at the earliest.
- Reset mid-EXEC or mid-WB aborts the instruction:
  - No write, no done.
  - All state returns to reset values.
- alu_y is sampled only at the EXEC→WB edge. The ALU's combinational path must settle within one cycle.

## Structure
- Shared package / params:
  - ALU op codes and ALU_OP_LEN, already shared.
  - Opcode constants MOV=4'b0110, LDI=4'b1110.
  - FSM state encoding IDLE/EXEC/WB.
  - Instruction field offsets.
- Sub-module core4_regfile:
  - NREGS×WIDTH flops with async active-low reset.
  - One write port with enable.
  - Three combinational read ports (rd, rs, dbg).
- Top level holds the FSM, decode and result/zflag registers.

## Test plan
- Reset then LDI r1,3 and LDI r2,5, then ADD r1,r2 → done at T+2, result=8, dbg r1=8, zflag=0.
- SUB r1,r2 with r1=3, r2=5 → result=4'hE, alu_op=SUB during EXEC; then SUB r3,r3 with r3=E → result 0, zflag=1.
- Immediate ops on r0=4'h9:
  - SRA imm=1 → 4'hC.
  - Reload 9, SRL imm=1 → 4'h4.
  - Reload 9, XOR imm=F → 4'h6.
  - NAND imm=F on 6 → 4'h9.
- Illegal 4'b0111 with r1=7 → done and err pulse together, result=0, r1 stays 7, zflag unchanged.
- Hold instr_valid high with changing instr during EXEC/WB → only the instruction latched at accept executes; instr_ready is low for exactly 2 cycles per instruction.
- Assert rst_n low during EXEC of ADD → no done, all registers 0, instr_ready=1 on release.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the 4-bit core's issue/writeback controller:
// ALU op codes, opcode constants, FSM encoding and instruction field offsets.
package alu_sequencer_pkg;

    localparam int DATA_W     = 4;
    localparam int NUM_REGS   = 4;
    localparam int REG_AW     = 2;
    localparam int ALU_OP_LEN = 3;
    localparam int INSTR_W    = 12;

    // Instruction layout: [11:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm
    localparam int OPC_LSB     = 8;
    localparam int OPC_W       = 4;
    localparam int RD_LSB      = 6;
    localparam int RS_LSB      = 4;
    localparam int IMM_LSB     = 0;
    localparam int IMM_W       = 4;
    localparam int OPC_IMM_BIT = 3;

    typedef enum logic [ALU_OP_LEN-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_NAND = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_SRL  = 3'd4,
        ALU_SRA  = 3'd5
    } alu_op_e;

    localparam logic [OPC_W-1:0] OPC_MOV = 4'b0110;
    localparam logic [OPC_W-1:0] OPC_LDI = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_alu_code(input logic [ALU_OP_LEN-1:0] code);
        return (code <= ALU_SRA);
    endfunction

endpackage

// File: rtl/core4_regfile.sv
// Register file for the 4-bit core: flop array with one write port and
// three combinational read ports (rd operand, rs operand, debug).
module core4_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS,
    parameter int AW    = REG_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [AW-1:0]    rs_addr_i,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [WIDTH-1:0] rs_data_o,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] wsel;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wsel
        assign wsel[gi] = we_i && (waddr_i == AW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs_q[i] <= wdata_i;
                end
            end
        end
    end

    assign rd_data_o  = regs_q[rd_addr_i];
    assign rs_data_o  = regs_q[rs_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller: accepts one instruction per 3 cycles, drives the
// external combinational ALU during EXEC and writes its result back in WB.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREGS = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [ALU_OP_LEN-1:0] alu_op,
    input  logic [WIDTH-1:0]      alu_y,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  zflag,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
);

    state_e               state_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [WIDTH-1:0]     result_q;
    logic                 done_q;
    logic                 err_q;
    logic                 zflag_q;

    logic [OPC_W-1:0]     opc;
    logic [REG_AW-1:0]    rd_addr;
    logic [REG_AW-1:0]    rs_addr;
    logic [IMM_W-1:0]     imm;
    logic [WIDTH-1:0]     rd_data;
    logic [WIDTH-1:0]     rs_data;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     result_d;
    logic                 is_alu;
    logic                 is_mov;
    logic                 is_ldi;
    logic                 legal;
    logic                 wr_en;

    // Decode works purely off the latched instruction, so instr has no path to alu_*.
    assign opc     = instr_q[OPC_LSB +: OPC_W];
    assign rd_addr = instr_q[RD_LSB +: REG_AW];
    assign rs_addr = instr_q[RS_LSB +: REG_AW];
    assign imm     = instr_q[IMM_LSB +: IMM_W];

    assign is_alu = is_alu_code(opc[ALU_OP_LEN-1:0]);
    assign is_mov = (opc == OPC_MOV);
    assign is_ldi = (opc == OPC_LDI);
    assign legal  = is_alu || is_mov || is_ldi;
    assign op_b   = opc[OPC_IMM_BIT] ? WIDTH'(imm) : rs_data;

    always_comb begin
        result_d = '0;
        if (is_mov) begin
            result_d = rs_data;
        end else if (is_ldi) begin
            result_d = WIDTH'(imm);
        end else if (is_alu) begin
            result_d = alu_y;
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        if (state_q == ST_EXEC) begin
            alu_a = rd_data;
            alu_b = op_b;
            if (is_alu) begin
                alu_op = opc[ALU_OP_LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    err_q    <= !legal;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (legal) begin
                        zflag_q <= (result_q == '0);
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en       = (state_q == ST_WB) && legal;
    assign instr_ready = (state_q == ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign zflag       = zflag_q;

    core4_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wr_en),
        .waddr_i    (rd_addr),
        .wdata_i    (result_q),
        .rd_addr_i  (rd_addr),
        .rs_addr_i  (rs_addr),
        .dbg_addr_i (dbg_addr),
        .rd_data_o  (rd_data),
        .rs_data_o  (rs_data),
        .dbg_data_o (dbg_data)
    );

endmodule
